// File: rtl/round_controller_pkg.sv
// round_ctrl_pkg: shared types and constants for the round controller.
//   state_e  - sequencer states (IDLE, ARM, RUN, SCORE, DONE)
//   diff_e   - difficulty codes handed to the reaction timer
//   TW_DEF   - timer value width for the default 4095 ms full scale
//   norm_diff() - maps the unused difficulty code 3 onto easy
package round_ctrl_pkg;

  localparam int unsigned MAX_MS_DEF = 4095;
  localparam int unsigned TW_DEF     = $clog2(MAX_MS_DEF);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    SCORE,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    DIFF_EASY = 2'd0,
    DIFF_MED  = 2'd1,
    DIFF_HARD = 2'd2
  } diff_e;

  function automatic logic [1:0] norm_diff(input logic [1:0] sel);
    return (sel == 2'd3) ? 2'(DIFF_EASY) : sel;
  endfunction

endpackage

// File: rtl/round_controller_if.sv
// round_controller_if: link between the round controller and the reaction timer.
//   timer_reset  controller -> timer   hold timer at zero
//   timer_enable controller -> timer   let the timer count
//   end_value    controller -> timer   timeout threshold for this round (ms)
//   difficulty   controller -> timer   difficulty latched at game start
//   timer_value  timer -> controller   elapsed milliseconds
//   end_reached  timer -> controller   elapsed time reached end_value
// master = controller side, slave = timer side.
interface round_controller_if #(
  parameter int unsigned TW = 12
);

  logic          timer_reset;
  logic          timer_enable;
  logic [TW-1:0] end_value;
  logic [1:0]    difficulty;
  logic [TW-1:0] timer_value;
  logic          end_reached;

  modport master (
    output timer_reset, timer_enable, end_value, difficulty,
    input  timer_value, end_reached
  );

  modport slave (
    input  timer_reset, timer_enable, end_value, difficulty,
    output timer_value, end_reached
  );

endinterface

// File: rtl/round_window_calc.sv
// round_window_calc: combinational per-round timeout window.
//   round_idx  in   IW  current 0-based round
//   end_value  out  TW  max(BASE_WINDOW_MS - round_idx*WINDOW_STEP_MS, MIN_WINDOW_MS)
// The subtraction is done signed in TW+8 bits so late rounds clamp to the
// floor instead of wrapping around to a huge window.
module round_window_calc #(
  parameter int unsigned TW             = 12,
  parameter int unsigned IW             = 4,
  parameter int unsigned BASE_WINDOW_MS = 2000,
  parameter int unsigned WINDOW_STEP_MS = 150,
  parameter int unsigned MIN_WINDOW_MS  = 400
) (
  input  logic [IW-1:0] round_idx,
  output logic [TW-1:0] end_value
);

  localparam int unsigned CW = TW + 8;

  localparam logic signed [CW-1:0] BASE_S = CW'(BASE_WINDOW_MS);
  localparam logic signed [CW-1:0] STEP_S = CW'(WINDOW_STEP_MS);
  localparam logic signed [CW-1:0] MIN_S  = CW'(MIN_WINDOW_MS);

  logic signed [CW-1:0] idx_s;
  logic signed [CW-1:0] step_prod;
  logic signed [CW-1:0] diff;

  always_comb begin
    idx_s     = signed'(CW'(round_idx));
    step_prod = idx_s * STEP_S;
    diff      = BASE_S - step_prod;
    end_value = (diff < MIN_S) ? TW'(MIN_WINDOW_MS) : TW'(diff);
  end

endmodule

// File: rtl/round_controller.sv
// round_controller: game-round sequencer in front of the millisecond reaction timer.
//   clk, reset      clock and synchronous active-high reset
//   start           1-cycle pulse, begins a game from IDLE or DONE
//   hit             1-cycle debounced player pulse, honoured only in RUN
//   difficulty_sel  0 easy, 1 medium, 2 hard (3 treated as easy)
//   tmr             timer link (master): timer_reset/enable, end_value,
//                   difficulty out; timer_value/end_reached in
//   round_idx       current 0-based round
//   score, misses   saturating hit / timeout counters
//   last_reaction   timer_value captured on the last valid hit
//   best_reaction   fastest hit of the game (all-ones when not tracked)
//   game_over       high in DONE
// Optional feature macro: ROUND_CTRL_BEST_EN enables best_reaction tracking.
// All outputs are flops loaded from the next-state decision, so each output
// already reflects the state it belongs to.
module round_controller
  import round_ctrl_pkg::*;
#(
  parameter int unsigned MAX_MS         = 4095,
  parameter int unsigned ROUNDS         = 10,
  parameter int unsigned BASE_WINDOW_MS = 2000,
  parameter int unsigned WINDOW_STEP_MS = 150,
  parameter int unsigned MIN_WINDOW_MS  = 400,
  parameter int unsigned SCORE_W        = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          hit,
  input  logic [1:0]                    difficulty_sel,
  round_controller_if.master            tmr,
  output logic [$clog2(ROUNDS+1)-1:0]   round_idx,
  output logic [SCORE_W-1:0]            score,
  output logic [SCORE_W-1:0]            misses,
  output logic [$clog2(MAX_MS)-1:0]     last_reaction,
  output logic [$clog2(MAX_MS)-1:0]     best_reaction,
  output logic                          game_over
);

  localparam int unsigned TW = $clog2(MAX_MS);
  localparam int unsigned RW = $clog2(ROUNDS + 1);
  localparam logic [RW-1:0]      LAST_ROUND = RW'(ROUNDS);
  localparam logic [SCORE_W-1:0] SAT_MAX    = '1;

  state_e              state_q, state_d;
  logic                timer_reset_q, timer_reset_d;
  logic                timer_enable_q, timer_enable_d;
  logic [TW-1:0]       end_value_q, end_value_d;
  logic [1:0]          difficulty_q, difficulty_d;
  logic [RW-1:0]       round_idx_q, round_idx_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  misses_q, misses_d;
  logic [TW-1:0]       last_q, last_d;
  logic                game_over_q, game_over_d;

  logic                start_game;
  logic                valid_hit;
  logic [TW-1:0]       window;

  assign start_game = start && ((state_q == IDLE) || (state_q == DONE));
  // A timeout in the same cycle as a hit counts as a miss.
  assign valid_hit  = (state_q == RUN) && !tmr.end_reached && hit;

  // Window is computed from the round index that ARM will present.
  round_window_calc #(
    .TW             (TW),
    .IW             (RW),
    .BASE_WINDOW_MS (BASE_WINDOW_MS),
    .WINDOW_STEP_MS (WINDOW_STEP_MS),
    .MIN_WINDOW_MS  (MIN_WINDOW_MS)
  ) u_window (
    .round_idx (round_idx_d),
    .end_value (window)
  );

  always_comb begin
    state_d      = state_q;
    difficulty_d = difficulty_q;
    round_idx_d  = round_idx_q;
    score_d      = score_q;
    misses_d     = misses_q;
    last_d       = last_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_game) begin
          difficulty_d = norm_diff(difficulty_sel);
          round_idx_d  = '0;
          score_d      = '0;
          misses_d     = '0;
          last_d       = '0;
          state_d      = ARM;
        end
      end
      ARM: state_d = RUN;
      RUN: begin
        if (tmr.end_reached) begin
          if (misses_q != SAT_MAX) misses_d = misses_q + 1'b1;
          state_d = SCORE;
        end else if (valid_hit) begin
          if (score_q != SAT_MAX) score_d = score_q + 1'b1;
          last_d  = tmr.timer_value;
          state_d = SCORE;
        end
      end
      SCORE: begin
        round_idx_d = round_idx_q + 1'b1;
        state_d     = (round_idx_d == LAST_ROUND) ? DONE : ARM;
      end
      default: state_d = IDLE;
    endcase

    timer_reset_d  = (state_d == IDLE) || (state_d == ARM) || (state_d == DONE);
    timer_enable_d = (state_d == RUN);
    game_over_d    = (state_d == DONE);
    // Window only changes on entry to ARM, so it is constant while enabled.
    end_value_d    = (state_d == ARM) ? window : end_value_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_reset_q  <= 1'b1;
      timer_enable_q <= 1'b0;
      end_value_q    <= '0;
      difficulty_q   <= '0;
      round_idx_q    <= '0;
      score_q        <= '0;
      misses_q       <= '0;
      last_q         <= '0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_reset_q  <= timer_reset_d;
      timer_enable_q <= timer_enable_d;
      end_value_q    <= end_value_d;
      difficulty_q   <= difficulty_d;
      round_idx_q    <= round_idx_d;
      score_q        <= score_d;
      misses_q       <= misses_d;
      last_q         <= last_d;
      game_over_q    <= game_over_d;
    end
  end

`ifdef ROUND_CTRL_BEST_EN
  logic [TW-1:0] best_q, best_d;

  always_comb begin
    best_d = best_q;
    if (start_game) begin
      best_d = '1;
    end else if (valid_hit && (tmr.timer_value < best_q)) begin
      best_d = tmr.timer_value;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) best_q <= '1;
    else       best_q <= best_d;
  end

  assign best_reaction = best_q;
`else
  assign best_reaction = '1;
`endif

  assign tmr.timer_reset  = timer_reset_q;
  assign tmr.timer_enable = timer_enable_q;
  assign tmr.end_value    = end_value_q;
  assign tmr.difficulty   = difficulty_q;
  assign round_idx        = round_idx_q;
  assign score            = score_q;
  assign misses           = misses_q;
  assign last_reaction    = last_q;
  assign game_over        = game_over_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller, paired with a millisecond timer model
// running at two clocks per millisecond. Also exercises round_window_calc
// directly for late rounds where the window floor applies.
module tb_round_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic        hit;
  logic [1:0]  difficulty_sel;
  logic [3:0]  round_idx;
  logic [7:0]  score;
  logic [7:0]  misses;
  logic [11:0] last_reaction;
  logic [11:0] best_reaction;
  logic        game_over;
  logic        tdiv;

  logic [3:0]  w_idx;
  logic [11:0] w_val;

  int vectors;
  int miscompares;

  round_controller_if #(.TW(12)) tmr ();

  round_controller #(
    .MAX_MS         (4095),
    .ROUNDS         (10),
    .BASE_WINDOW_MS (2000),
    .WINDOW_STEP_MS (150),
    .MIN_WINDOW_MS  (400),
    .SCORE_W        (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .hit            (hit),
    .difficulty_sel (difficulty_sel),
    .tmr            (tmr.master),
    .round_idx      (round_idx),
    .score          (score),
    .misses         (misses),
    .last_reaction  (last_reaction),
    .best_reaction  (best_reaction),
    .game_over      (game_over)
  );

  round_window_calc #(
    .TW             (12),
    .IW             (4),
    .BASE_WINDOW_MS (2000),
    .WINDOW_STEP_MS (150),
    .MIN_WINDOW_MS  (400)
  ) u_calc (
    .round_idx (w_idx),
    .end_value (w_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Timer model: CLKS_PER_MS = 2.
  always @(posedge clk) begin
    if (tmr.timer_reset === 1'b1) begin
      tmr.timer_value <= 12'd0;
      tdiv            <= 1'b0;
    end else if (tmr.timer_enable === 1'b1) begin
      if (tdiv) begin
        if (tmr.timer_value != 12'hFFF) tmr.timer_value <= tmr.timer_value + 12'd1;
        tdiv <= 1'b0;
      end else begin
        tdiv <= 1'b1;
      end
    end
  end

  assign tmr.end_reached = tmr.timer_enable && (tmr.timer_value >= tmr.end_value);

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_value(input int v, input string tag);
    int n = 0;
    while (int'(tmr.timer_value) != v && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(tmr.timer_value), v);
  endtask

  task automatic wait_enable(input logic lvl, input string tag);
    int n = 0;
    while (tmr.timer_enable !== lvl && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(tmr.timer_enable), int'(lvl));
  endtask

  initial begin
    int hv [3];
    int exp_win;
    int idx_list [5];
    int win_list [5];
    int n;

    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    start          = 1'b0;
    hit            = 1'b0;
    difficulty_sel = 2'd0;
    w_idx          = 4'd0;
    hv             = '{120, 80, 95};
    idx_list       = '{9, 10, 11, 12, 15};
    win_list       = '{650, 500, 400, 400, 400};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_timer_reset",  int'(tmr.timer_reset), 1);
    chk("rst_timer_enable", int'(tmr.timer_enable), 0);
    chk("rst_end_value",    int'(tmr.end_value), 0);
    chk("rst_difficulty",   int'(tmr.difficulty), 0);
    chk("rst_round_idx",    int'(round_idx), 0);
    chk("rst_score",        int'(score), 0);
    chk("rst_misses",       int'(misses), 0);
    chk("rst_last",         int'(last_reaction), 0);
    chk("rst_best",         int'(best_reaction), 4095);
    chk("rst_game_over",    int'(game_over), 0);
    reset = 1'b0;

    // Hit in IDLE is ignored
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    chk("idle_hit_timer_reset", int'(tmr.timer_reset), 1);
    chk("idle_hit_score",       int'(score), 0);

    // Game A: hard difficulty, hits at 120, 80, 95
    difficulty_sel = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("a_arm_timer_reset",  int'(tmr.timer_reset), 1);
    chk("a_arm_timer_enable", int'(tmr.timer_enable), 0);
    chk("a_arm_end_value",    int'(tmr.end_value), 2000);
    chk("a_arm_difficulty",   int'(tmr.difficulty), 2);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    chk("a_run_enable",      int'(tmr.timer_enable), 1);
    chk("a_run_timer_reset", int'(tmr.timer_reset), 0);
    chk("a_arm_hit_score",   int'(score), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("a_run_start_enable", int'(tmr.timer_enable), 1);
    chk("a_run_start_round",  int'(round_idx), 0);

    for (int r = 0; r < 3; r++) begin
      wait_value(hv[r], "a_wait_hit_value");
      hit = 1'b1;
      @(negedge clk);
      hit = 1'b0;
      chk("a_score_after_hit", int'(score), r + 1);
      chk("a_last_reaction",   int'(last_reaction), hv[r]);
      chk("a_score_enable",    int'(tmr.timer_enable), 0);
      hit = 1'b1;
      @(negedge clk);
      hit = 1'b0;
      chk("a_score_hit_ignored", int'(score), r + 1);
      chk("a_next_round_idx",    int'(round_idx), r + 1);
      chk("a_next_end_value",    int'(tmr.end_value), 2000 - 150 * (r + 1));
      @(negedge clk);
    end
`ifdef ROUND_CTRL_BEST_EN
    chk("a_best_reaction", int'(best_reaction), 80);
`else
    chk("a_best_reaction", int'(best_reaction), 4095);
`endif
    chk("a_last_final", int'(last_reaction), 95);

    // Reset mid-RUN at round 3
    repeat (5) @(negedge clk);
    chk("a_pre_reset_round",  int'(round_idx), 3);
    chk("a_pre_reset_enable", int'(tmr.timer_enable), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_timer_reset",  int'(tmr.timer_reset), 1);
    chk("abort_timer_enable", int'(tmr.timer_enable), 0);
    chk("abort_score",        int'(score), 0);
    chk("abort_round_idx",    int'(round_idx), 0);
    chk("abort_game_over",    int'(game_over), 0);
    chk("abort_best",         int'(best_reaction), 4095);

    // Game B: medium, hit at 37, then simultaneous hit and timeout
    difficulty_sel = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wait_value(37, "b_wait_37");
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    chk("b_score",         int'(score), 1);
    chk("b_last_reaction", int'(last_reaction), 37);
    @(negedge clk);
    chk("b_round_idx",   int'(round_idx), 1);
    chk("b_end_value",   int'(tmr.end_value), 1850);
    chk("b_difficulty",  int'(tmr.difficulty), 1);
    chk("b_arm_reset",   int'(tmr.timer_reset), 1);
    @(negedge clk);
    n = 0;
    while (tmr.end_reached !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("b_end_reached_seen", int'(tmr.end_reached), 1);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    chk("b_tie_misses", int'(misses), 1);
    chk("b_tie_score",  int'(score), 1);
    chk("b_tie_last",   int'(last_reaction), 37);
    chk("b_tie_enable", int'(tmr.timer_enable), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Game C: medium, never hit
    difficulty_sel = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 10; r++) begin
      wait_enable(1'b1, "c_wait_run");
      exp_win = 2000 - 150 * r;
      if (exp_win < 400) exp_win = 400;
      chk("c_end_value", int'(tmr.end_value), exp_win);
      chk("c_round_idx", int'(round_idx), r);
      wait_enable(1'b0, "c_wait_timeout");
    end
    @(negedge clk);
    chk("c_game_over",   int'(game_over), 1);
    chk("c_misses",      int'(misses), 10);
    chk("c_score",       int'(score), 0);
    chk("c_round_idx",   int'(round_idx), 10);
    chk("c_timer_reset", int'(tmr.timer_reset), 1);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    chk("done_hit_game_over", int'(game_over), 1);
    chk("done_hit_misses",    int'(misses), 10);

    // Restart from DONE with code 3 (treated as easy)
    difficulty_sel = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_difficulty", int'(tmr.difficulty), 0);
    chk("restart_game_over",  int'(game_over), 0);
    chk("restart_misses",     int'(misses), 0);
    chk("restart_round_idx",  int'(round_idx), 0);
    chk("restart_end_value",  int'(tmr.end_value), 2000);

    // Window calculator: late rounds and floor
    for (int i = 0; i < 5; i++) begin
      w_idx = 4'(idx_list[i]);
      #1;
      chk("calc_window", int'(w_val), win_list[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
